// File: rtl/pq_pkg.sv
// Shared types and helpers for the priority-queue command generator.
package pq_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned VAL_W  = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_REMOVE = 1'b1
  } pq_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cg_state_t;

  // Taps 8,6,5,4 (maximal length).
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // An all-zero seed would lock the register up.
  function automatic logic [LFSR_W-1:0] lfsr_fix_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

endpackage

// File: rtl/pq_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and step enable.
module pq_lfsr8
  import pq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = lfsr_fix_seed(seed);
    end else if (en) begin
      q_d = lfsr_step(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= lfsr_fix_seed(RESET_SEED);
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pq_cmd_gen.sv
// Command generator: fills the priority queue with pseudo-random inserts,
// then drains it with removes until empty, pulsing done at the end.
module pq_cmd_gen
  import pq_pkg::*;
#(
  parameter int unsigned       N_INSERT  = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             full,
  input  logic             empty,
  input  logic             req_ready,
  output logic             req_valid,
  output pq_op_t           req_op,
  output logic [KEY_W-1:0] req_key,
  output logic [VAL_W-1:0] req_val,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ins_count
);

  cg_state_t         state_q, state_d;
  logic              valid_q, valid_d;
  pq_op_t            op_q, op_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [VAL_W-1:0]  val_q, val_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  ins_count_q, ins_count_d;

  logic              lfsr_load;
  logic              lfsr_en;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_nxt;

  pq_lfsr8 #(
    .RESET_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .en   (lfsr_en),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Next state, LFSR control and next registered outputs.
  always_comb begin
    state_d     = state_q;
    ins_count_d = ins_count_q;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FILL;
          lfsr_load   = 1'b1;
          ins_count_d = '0;
        end
      end
      FILL: begin
        if (full) begin
          state_d = DRAIN;
        end else if (req_ready) begin
          lfsr_en     = 1'b1;
          ins_count_d = ins_count_q + CNT_W'(1);
          if (ins_count_q == CNT_W'(N_INSERT - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Mirror of the LFSR's own update so the payload register tracks it.
    lfsr_nxt = lfsr_q;
    if (lfsr_load) begin
      lfsr_nxt = lfsr_fix_seed(LFSR_SEED);
    end else if (lfsr_en) begin
      lfsr_nxt = lfsr_step(lfsr_q);
    end

    valid_d = (state_d == FILL) || (state_d == DRAIN);
    op_d    = (state_d == DRAIN) ? OP_REMOVE : OP_INSERT;
    key_d   = (state_d == FILL) ? lfsr_nxt[KEY_W-1:0] : '0;
    val_d   = (state_d == FILL) ? lfsr_nxt[LFSR_W-1:KEY_W] : '0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      op_q        <= OP_INSERT;
      key_q       <= '0;
      val_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ins_count_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      op_q        <= op_d;
      key_q       <= key_d;
      val_q       <= val_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ins_count_q <= ins_count_d;
    end
  end

  // Only full (in FILL) and empty (in DRAIN) may withdraw a presented command.
  assign req_valid = valid_q
                   & ~((state_q == FILL)  & full)
                   & ~((state_q == DRAIN) & empty);
  assign req_op    = op_q;
  assign req_key   = key_q;
  assign req_val   = val_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ins_count = ins_count_q;

endmodule

// File: tb/tb_pq_cmd_gen.sv
// Directed self-checking bench for pq_cmd_gen.
module tb_pq_cmd_gen;
  import pq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       full;
  logic       empty;
  logic       req_ready;
  logic       req_valid;
  pq_op_t     req_op;
  logic [3:0] req_key;
  logic [3:0] req_val;
  logic       busy;
  logic       done;
  logic [3:0] ins_count;

  int total = 0;
  int bad   = 0;
  int rm;

  // Hand-stepped LFSR sequence from seed A5.
  logic [7:0] ins_tab [8] = '{8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54, 8'hA9, 8'h53, 8'hA7};
  logic [7:0] cur;

  pq_cmd_gen #(.N_INSERT(8), .LFSR_SEED(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .full      (full),
    .empty     (empty),
    .req_ready (req_ready),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_key   (req_key),
    .req_val   (req_val),
    .busy      (busy),
    .done      (done),
    .ins_count (ins_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 8'(req_valid), 8'h0);
    chk({tag, "_op"},    8'(req_op),    8'h0);
    chk({tag, "_key"},   8'(req_key),   8'h0);
    chk({tag, "_val"},   8'(req_val),   8'h0);
    chk({tag, "_busy"},  8'(busy),      8'h0);
    chk({tag, "_done"},  8'(done),      8'h0);
    chk({tag, "_cnt"},   8'(ins_count), 8'h0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; full = 1'b0; empty = 1'b0; req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b1;
    cyc();

    // Full run with ready always high.
    start = 1'b1; #1;
    chk("idle_busy", 8'(busy), 8'h0);
    cyc(); start = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      cur = ins_tab[i];
      chk($sformatf("fill%0d_valid", i), 8'(req_valid), 8'h1);
      chk($sformatf("fill%0d_op", i),    8'(req_op),    8'h0);
      chk($sformatf("fill%0d_key", i),   8'(req_key),   8'(cur[3:0]));
      chk($sformatf("fill%0d_val", i),   8'(req_val),   8'(cur[7:4]));
      chk($sformatf("fill%0d_cnt", i),   8'(ins_count), 8'(i));
      cyc(); #1;
    end
    chk("drain_op",    8'(req_op),    8'h1);
    chk("drain_valid", 8'(req_valid), 8'h1);
    chk("drain_key",   8'(req_key),   8'h0);
    chk("drain_cnt",   8'(ins_count), 8'h8);
    empty = 1'b1; #1;
    chk("empty_drop", 8'(req_valid), 8'h0);
    cyc(); empty = 1'b0; #1;
    chk("done1",       8'(done),      8'h1);
    chk("done1_busy",  8'(busy),      8'h1);
    chk("done1_valid", 8'(req_valid), 8'h0);
    cyc(); #1;
    chk("idle_done",   8'(done),      8'h0);
    chk("idle_busy2",  8'(busy),      8'h0);
    chk("idle_cnt",    8'(ins_count), 8'h8);

    // Stall on the first insert.
    start = 1'b1;
    cyc(); start = 1'b0; req_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d_valid", i), 8'(req_valid), 8'h1);
      chk($sformatf("stall%0d_key", i),   8'(req_key),   8'h5);
      chk($sformatf("stall%0d_val", i),   8'(req_val),   8'hA);
      chk($sformatf("stall%0d_cnt", i),   8'(ins_count), 8'h0);
      cyc(); #1;
    end
    req_ready = 1'b1; #1;
    chk("unstall_key", 8'(req_key), 8'h5);
    cyc(); #1;
    chk("after_stall_key", 8'(req_key),   8'hA);
    chk("after_stall_val", 8'(req_val),   8'h4);
    chk("after_stall_cnt", 8'(ins_count), 8'h1);
    cyc(); #1;
    cyc(); #1;
    chk("pre_full_cnt", 8'(ins_count), 8'h3);

    // Full withdraws the command even with ready high.
    full = 1'b1; #1;
    chk("full_drop", 8'(req_valid), 8'h0);
    cyc(); #1;
    chk("full_drain_op",    8'(req_op),    8'h1);
    chk("full_drain_valid", 8'(req_valid), 8'h1);
    chk("full_drain_cnt",   8'(ins_count), 8'h3);
    full = 1'b0;

    // Two removes, then empty.
    rm = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (req_valid && req_ready && req_op == OP_REMOVE) rm++;
      cyc();
    end
    empty = 1'b1; #1;
    chk("rm_empty_drop", 8'(req_valid), 8'h0);
    chk("rm_count",      8'(rm),        8'h2);
    cyc(); empty = 1'b0; #1;
    chk("rm_done", 8'(done), 8'h1);
    cyc(); #1;
    chk("rm_done_off", 8'(done), 8'h0);
    chk("rm_busy_off", 8'(busy), 8'h0);

    // Reset mid-fill.
    start = 1'b1;
    cyc(); start = 1'b0; #1;
    repeat (4) begin cyc(); #1; end
    chk("pre_rst_cnt", 8'(ins_count), 8'h4);
    chk("pre_rst_key", 8'(req_key),   8'h4);
    rst = 1'b0; #1;
    chk_reset("rst_mid");
    cyc(); cyc();
    rst = 1'b1;
    cyc(); #1;
    chk("post_rst_done", 8'(done), 8'h0);
    chk("post_rst_busy", 8'(busy), 8'h0);
    start = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("restart_key", 8'(req_key),   8'h5);
    chk("restart_val", 8'(req_val),   8'hA);
    chk("restart_cnt", 8'(ins_count), 8'h0);

    // Start pulses outside IDLE are ignored.
    cyc(); #1;
    start = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("st_fill_key", 8'(req_key),   8'h5);
    chk("st_fill_val", 8'(req_val),   8'h9);
    chk("st_fill_cnt", 8'(ins_count), 8'h2);
    repeat (6) begin cyc(); #1; end
    chk("st_drain_op",  8'(req_op),    8'h1);
    chk("st_drain_cnt", 8'(ins_count), 8'h8);
    req_ready = 1'b0; start = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("st_drain_op2",   8'(req_op),    8'h1);
    chk("st_drain_valid", 8'(req_valid), 8'h1);
    chk("st_drain_cnt2",  8'(ins_count), 8'h8);
    empty = 1'b1;
    cyc(); empty = 1'b0; start = 1'b1; #1;
    chk("st_done", 8'(done), 8'h1);
    cyc(); start = 1'b0; #1;
    chk("st_done_busy", 8'(busy),      8'h0);
    chk("st_done_cnt",  8'(ins_count), 8'h8);
    chk("st_done_off",  8'(done),      8'h0);
    cyc(); #1;
    chk("st_idle_busy",  8'(busy),      8'h0);
    chk("st_idle_valid", 8'(req_valid), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pq_cmd_gen.md
PQ_CMD_GEN -- requirements
Module: pq_cmd_gen

Interface
REQ-001 SHALL have parameter N_INSERT, default 8, the number of insert commands issued per run (range 1..15).
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5, the LFSR load value at reset and at run start.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle run-request pulse from the single-pulser.
REQ-006 full  input  1  queue-full flag from the priority-queue core.
REQ-007 empty  input  1  queue-empty flag from the priority-queue core.
REQ-008 req_ready  input  1  the core accepts the current command.
REQ-009 req_valid  output  1  a command is presented.
REQ-010 req_op  output  pq_op_t  OP_INSERT or OP_REMOVE.
REQ-011 req_key  output  4  insert priority key; 0 for removes.
REQ-012 req_val  output  4  insert data value; 0 for removes.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 done  output  1  one-cycle pulse at run completion.
REQ-015 ins_count  output  4  inserts accepted in the current run.

Function
REQ-016 SHALL run an FSM with states IDLE, FILL, DRAIN and DONE.
REQ-017 IDLE: start=1 moves the FSM to FILL, reloads the LFSR with LFSR_SEED and clears ins_count; start is ignored in all other states.
REQ-018 FILL: req_valid=1, req_op=OP_INSERT, req_key=lfsr[3:0], req_val=lfsr[7:4].
REQ-019 A transfer occurs on a cycle with req_valid & req_ready; zero bubble cycles are allowed between transfers.
REQ-020 Payload SHALL stay stable while req_valid=1 and req_ready=0, except as allowed by REQ-023.
REQ-021 On each insert transfer the LFSR SHALL advance one step as {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}, and ins_count SHALL increment.
REQ-022 FILL moves to DRAIN on the transfer that brings ins_count to N_INSERT.
REQ-023 If full=1 in FILL, the block SHALL drop req_valid in that cycle (withdrawal permitted only here), ignore req_ready, and move to DRAIN next cycle; full takes priority over a simultaneous req_ready.
REQ-024 DRAIN: req_valid=1, req_op=OP_REMOVE, key/val=0; each transfer is one remove.
REQ-025 If empty=1 in DRAIN, req_valid SHALL drop the same cycle and the FSM moves to DONE; empty takes priority over req_ready.
REQ-026 DONE lasts exactly one cycle with done=1, then returns to IDLE; ins_count holds its value until the next start.
REQ-027 A seed of 8'h00 SHALL be replaced by 8'h01 so the LFSR never locks up.
REQ-028 Outputs SHALL be registered, or decoded only from state and registers, with no combinational path from inputs, except the req_valid drop in REQ-023 and REQ-025.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE with req_valid=0, req_op=OP_INSERT, key/val=0, busy=0, done=0, ins_count=0 and lfsr=LFSR_SEED.
REQ-030 Reset mid-run SHALL abandon the run with no done pulse; the next start begins a fresh run from the seed.

Structure
REQ-031 pq_op_t (OP_INSERT=1'b0, OP_REMOVE=1'b1) and the cmd-gen state enum SHALL live in pq_pkg.
REQ-032 The LFSR SHALL be a sub-module, pq_lfsr8, with ports clk, rst, load, en, seed and q.

Verification
REQ-033 Seed A5, req_ready=1, full=empty=0: start -> inserts (key,val) = (5,A), (A,4), (5,9) on consecutive cycles; ins_count reaches 8 and the FSM enters DRAIN.
REQ-034 req_ready=0 for 3 cycles during the first insert -> req_valid stays 1 with (5,A) stable; the transfer occurs on the cycle req_ready rises.
REQ-035 full=1 after the 3rd insert transfer -> req_valid drops the same cycle, DRAIN begins, and ins_count=3.
REQ-036 DRAIN with empty raised after 2 removes -> exactly 2 OP_REMOVE transfers, then done=1 for one cycle, then busy=0.
REQ-037 rst=0 asserted in FILL after 4 inserts -> all outputs reach reset values immediately; a new start reissues (5,A) first.
REQ-038 start pulsed in FILL, DRAIN and DONE -> no effect on state, LFSR or ins_count.
